// File: rtl/decode_queue_if.sv
// Fetch-side and decode-side handshake bundle for decode_queue.
// The slave modport is the queue's view; master is the view of whatever drives it.
interface decode_queue_if #(
  parameter int PTR_W = 2
);
  // fetch side
  logic             fetch_valid_i;
  logic [31:0]      fetch_instr_i;
  logic [31:0]      fetch_pc_i;
  logic             fetch_ready_o;
  // decode side
  logic             dec_ready_i;
  logic             dec_valid_o;
  logic [31:0]      dec_pc_o;
  logic [4:0]       rs_dec_o;
  logic [4:0]       rt_dec_o;
  logic [4:0]       rd_dec_o;
  logic [4:0]       shamt_dec_o;
  logic [5:0]       op_dec_o;
  logic [5:0]       funct_dec_o;
  logic [25:0]      target_dec_o;
  logic [31:0]      sign_imm_dec_o;
  logic             is_r_type_dec_o;
  logic             is_i_type_dec_o;
  logic             is_j_type_dec_o;
  logic             use_link_reg_dec_o;
  logic [4:0]       wr_reg_dec_o;
  logic [PTR_W:0]   count_o;

  modport slave (
    input  fetch_valid_i, fetch_instr_i, fetch_pc_i, dec_ready_i,
    output fetch_ready_o, dec_valid_o, dec_pc_o, rs_dec_o, rt_dec_o, rd_dec_o,
           shamt_dec_o, op_dec_o, funct_dec_o, target_dec_o, sign_imm_dec_o,
           is_r_type_dec_o, is_i_type_dec_o, is_j_type_dec_o,
           use_link_reg_dec_o, wr_reg_dec_o, count_o
  );

  modport master (
    output fetch_valid_i, fetch_instr_i, fetch_pc_i, dec_ready_i,
    input  fetch_ready_o, dec_valid_o, dec_pc_o, rs_dec_o, rt_dec_o, rd_dec_o,
           shamt_dec_o, op_dec_o, funct_dec_o, target_dec_o, sign_imm_dec_o,
           is_r_type_dec_o, is_i_type_dec_o, is_j_type_dec_o,
           use_link_reg_dec_o, wr_reg_dec_o, count_o
  );
endinterface

// File: rtl/decode_queue.sv
// Buffered MIPS decoder: a DEPTH-entry instruction/PC FIFO feeding one
// registered decode stage. An empty queue lets a fetch bypass straight into
// the output stage, giving one-cycle latency and one instruction per cycle.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush_i,
  decode_queue_if.slave  bus
);

  localparam logic [PTR_W-1:0] PTR_ONE   = {{(PTR_W-1){1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_ONE   = {{PTR_W{1'b0}}, 1'b1};
  localparam logic [PTR_W:0]   CNT_DEPTH = (PTR_W+1)'(DEPTH);

  // FIFO state
  logic [31:0]      r_instr_mem [DEPTH];
  logic [31:0]      r_pc_mem    [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  // output stage
  logic             r_dec_valid;
  logic [31:0]      r_dec_pc;
  logic [31:0]      r_dec_instr;
  logic [31:0]      r_sign_imm;
  logic             r_is_r;
  logic             r_is_i;
  logic             r_is_j;
  logic             r_link;
  logic [4:0]       r_wr_reg;

  // handshake / selection
  logic             w_fetch_ready;
  logic             w_accept;
  logic             w_from_fifo;
  logic             w_load;
  logic             w_pop;
  logic             w_write;
  logic [31:0]      w_sel_instr;
  logic [31:0]      w_sel_pc;

  // decode of the selected instruction
  logic [5:0]       w_op;
  logic [4:0]       w_rt;
  logic [4:0]       w_rd;
  logic [5:0]       w_funct;
  logic [15:0]      w_imm;
  logic [31:0]      w_sign_imm;
  logic             w_is_r;
  logic             w_is_i;
  logic             w_is_j;
  logic             w_link;
  logic [4:0]       w_wr_reg;

  // Handshake and source selection; a full queue refuses fetch regardless of a same-cycle pop.
  always_comb begin
    w_fetch_ready = (r_count < CNT_DEPTH);
    w_accept      = bus.fetch_valid_i && w_fetch_ready && !flush_i;
    w_from_fifo   = (r_count != {(PTR_W+1){1'b0}});
    w_load        = (!r_dec_valid || bus.dec_ready_i) && (w_from_fifo || w_accept);
    w_pop         = w_load && w_from_fifo;
    // a bypassed fetch goes straight to the output stage and skips the FIFO
    w_write       = w_accept && !(w_load && !w_from_fifo);
    if (w_from_fifo) begin
      w_sel_instr = r_instr_mem[r_rd_ptr];
      w_sel_pc    = r_pc_mem[r_rd_ptr];
    end else begin
      w_sel_instr = bus.fetch_instr_i;
      w_sel_pc    = bus.fetch_pc_i;
    end
  end

  // Decode the selected instruction: format class, extension, link and destination.
  always_comb begin
    w_op     = w_sel_instr[31:26];
    w_rt     = w_sel_instr[20:16];
    w_rd     = w_sel_instr[15:11];
    w_funct  = w_sel_instr[5:0];
    w_imm    = w_sel_instr[15:0];
    w_is_r   = (w_op == 6'h00);
    w_is_j   = (w_op == 6'h02) || (w_op == 6'h03);
    w_is_i   = !w_is_r && !w_is_j;
    // logical immediates (andi/ori/xori) zero-extend, everything else sign-extends
    if ((w_op == 6'h0C) || (w_op == 6'h0D) || (w_op == 6'h0E)) begin
      w_sign_imm = {16'h0000, w_imm};
    end else begin
      w_sign_imm = {{16{w_imm[15]}}, w_imm};
    end
    // bltzal/bgezal, jal, jalr
    w_link = ((w_op == 6'h01) && ((w_rt == 5'h10) || (w_rt == 5'h11))) ||
             (w_op == 6'h03) ||
             ((w_op == 6'h00) && (w_funct == 6'h09));
    if (w_is_r) begin
      w_wr_reg = w_rd;
    end else if ((w_op == 6'h03) || ((w_op == 6'h01) && w_link)) begin
      w_wr_reg = 5'd31;
    end else begin
      w_wr_reg = w_rt;
    end
  end

  // FIFO storage, pointers and occupancy; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      r_wr_ptr <= {PTR_W{1'b0}};
      r_rd_ptr <= {PTR_W{1'b0}};
      r_count  <= {(PTR_W+1){1'b0}};
    end else begin
      if (w_write) begin
        r_instr_mem[r_wr_ptr] <= bus.fetch_instr_i;
        r_pc_mem[r_wr_ptr]    <= bus.fetch_pc_i;
        r_wr_ptr              <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_write, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output stage: load when free or being consumed, drain when consumed with nothing new.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dec_valid <= 1'b0;
      r_dec_pc    <= 32'h0000_0000;
      r_dec_instr <= 32'h0000_0000;
      r_sign_imm  <= 32'h0000_0000;
      r_is_r      <= 1'b0;
      r_is_i      <= 1'b0;
      r_is_j      <= 1'b0;
      r_link      <= 1'b0;
      r_wr_reg    <= 5'd0;
    end else if (flush_i) begin
      r_dec_valid <= 1'b0;
    end else if (w_load) begin
      r_dec_valid <= 1'b1;
      r_dec_pc    <= w_sel_pc;
      r_dec_instr <= w_sel_instr;
      r_sign_imm  <= w_sign_imm;
      r_is_r      <= w_is_r;
      r_is_i      <= w_is_i;
      r_is_j      <= w_is_j;
      r_link      <= w_link;
      r_wr_reg    <= w_wr_reg;
    end else if (bus.dec_ready_i) begin
      r_dec_valid <= 1'b0;
    end
  end

  assign bus.fetch_ready_o      = w_fetch_ready;
  assign bus.count_o            = r_count;
  assign bus.dec_valid_o        = r_dec_valid;
  assign bus.dec_pc_o           = r_dec_pc;
  assign bus.op_dec_o           = r_dec_instr[31:26];
  assign bus.rs_dec_o           = r_dec_instr[25:21];
  assign bus.rt_dec_o           = r_dec_instr[20:16];
  assign bus.rd_dec_o           = r_dec_instr[15:11];
  assign bus.shamt_dec_o        = r_dec_instr[10:6];
  assign bus.funct_dec_o        = r_dec_instr[5:0];
  assign bus.target_dec_o       = r_dec_instr[25:0];
  assign bus.sign_imm_dec_o     = r_sign_imm;
  assign bus.is_r_type_dec_o    = r_is_r;
  assign bus.is_i_type_dec_o    = r_is_i;
  assign bus.is_j_type_dec_o    = r_is_j;
  assign bus.use_link_reg_dec_o = r_link;
  assign bus.wr_reg_dec_o       = r_wr_reg;

endmodule

// File: tb/tb_decode_queue.sv
// Directed self-checking bench for decode_queue: decode fields, extension,
// link decode, backpressure/full, push+pop wrap, flush and mid-stream reset.
module tb_decode_queue;
  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic flush_i;
  int   n_cmp = 0;
  int   n_err = 0;

  // free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  decode_queue_if #(.PTR_W(PTR_W)) dq_if ();

  decode_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush_i),
    .bus     (dq_if)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance one clock and sample just after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [31:0] ins, input logic [31:0] pc);
    dq_if.fetch_valid_i = 1'b1;
    dq_if.fetch_instr_i = ins;
    dq_if.fetch_pc_i    = pc;
  endtask

  task automatic chk_vc(input string tag, input logic v, input int cnt, input logic [31:0] pc);
    check_eq({tag, "_valid"}, 32'(dq_if.dec_valid_o), 32'(v));
    check_eq({tag, "_count"}, 32'(dq_if.count_o), 32'(cnt));
    check_eq({tag, "_pc"}, dq_if.dec_pc_o, pc);
  endtask

  task automatic chk_cls(input string tag, input logic r, input logic i, input logic j,
                         input logic lnk, input logic [4:0] wr);
    check_eq({tag, "_is_r"}, 32'(dq_if.is_r_type_dec_o), 32'(r));
    check_eq({tag, "_is_i"}, 32'(dq_if.is_i_type_dec_o), 32'(i));
    check_eq({tag, "_is_j"}, 32'(dq_if.is_j_type_dec_o), 32'(j));
    check_eq({tag, "_link"}, 32'(dq_if.use_link_reg_dec_o), 32'(lnk));
    check_eq({tag, "_wr"},   32'(dq_if.wr_reg_dec_o), 32'(wr));
  endtask

  initial begin
    rst_n               = 1'b0;
    flush_i             = 1'b0;
    dq_if.fetch_valid_i = 1'b0;
    dq_if.fetch_instr_i = 32'h0000_0000;
    dq_if.fetch_pc_i    = 32'h0000_0000;
    dq_if.dec_ready_i   = 1'b0;
    step();
    step();
    chk_vc("rst", 1'b0, 0, 32'h0);
    check_eq("rst_ready", 32'(dq_if.fetch_ready_o), 32'd1);
    check_eq("rst_imm", dq_if.sign_imm_dec_o, 32'h0);
    check_eq("rst_wr", 32'(dq_if.wr_reg_dec_o), 32'd0);
    rst_n = 1'b1;
    step();

    // add $8,$9,$10 with bypass: one-cycle latency
    dq_if.dec_ready_i = 1'b1;
    present(32'h012A_4020, 32'h0040_0000);
    step();
    chk_vc("add", 1'b1, 0, 32'h0040_0000);
    check_eq("add_rs", 32'(dq_if.rs_dec_o), 32'd9);
    check_eq("add_rt", 32'(dq_if.rt_dec_o), 32'd10);
    check_eq("add_rd", 32'(dq_if.rd_dec_o), 32'd8);
    check_eq("add_funct", 32'(dq_if.funct_dec_o), 32'h20);
    chk_cls("add", 1'b1, 1'b0, 1'b0, 1'b0, 5'd8);

    present(32'h3508_FFFF, 32'h0040_0004);            // ori: zero-extend
    step();
    check_eq("ori_imm", dq_if.sign_imm_dec_o, 32'h0000_FFFF);
    chk_cls("ori", 1'b0, 1'b1, 1'b0, 1'b0, 5'd8);

    present(32'h2108_FFFF, 32'h0040_0008);            // addi: sign-extend
    step();
    check_eq("addi_imm", dq_if.sign_imm_dec_o, 32'hFFFF_FFFF);
    chk_cls("addi", 1'b0, 1'b1, 1'b0, 1'b0, 5'd8);

    present(32'h0C10_0000, 32'h0040_000C);            // jal
    step();
    check_eq("jal_target", 32'(dq_if.target_dec_o), 32'h0010_0000);
    check_eq("jal_op", 32'(dq_if.op_dec_o), 32'h3);
    chk_cls("jal", 1'b0, 1'b0, 1'b1, 1'b1, 5'd31);

    present(32'h0411_0004, 32'h0040_0010);            // bgezal
    step();
    check_eq("bgezal_imm", dq_if.sign_imm_dec_o, 32'h0000_0004);
    chk_cls("bgezal", 1'b0, 1'b1, 1'b0, 1'b1, 5'd31);

    present(32'h0120_F809, 32'h0040_0014);            // jalr $31,$9
    step();
    chk_cls("jalr", 1'b1, 1'b0, 1'b0, 1'b1, 5'd31);

    present(32'h8D09_FFFC, 32'h0040_0018);            // lw $9,-4($8)
    step();
    check_eq("lw_imm", dq_if.sign_imm_dec_o, 32'hFFFF_FFFC);
    chk_cls("lw", 1'b0, 1'b1, 1'b0, 1'b0, 5'd9);

    present(32'h0800_0010, 32'h0040_001C);            // j: no link, wr=rt=0
    step();
    check_eq("j_target", 32'(dq_if.target_dec_o), 32'h10);
    chk_cls("j", 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);

    dq_if.fetch_valid_i = 1'b0;
    step();
    chk_vc("drain", 1'b0, 0, 32'h0040_001C);

    // backpressure: stream 6 fetches, output holds the 1st, queue fills to 4
    dq_if.dec_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check_eq($sformatf("bp_ready%0d", i), 32'(dq_if.fetch_ready_o), 32'((i < 5) ? 1 : 0));
      present(32'h2108_0000 | 32'(i), 32'h0000_1000 + 32'(4 * i));
      step();
      chk_vc($sformatf("bp%0d", i), 1'b1, (i < 5) ? i : 4, 32'h0000_1000);
    end
    dq_if.fetch_valid_i = 1'b0;
    dq_if.dec_ready_i   = 1'b1;
    for (int i = 1; i < 5; i++) begin
      step();
      chk_vc($sformatf("rel%0d", i), 1'b1, 4 - i, 32'h0000_1000 + 32'(4 * i));
      check_eq($sformatf("rel%0d_imm", i), dq_if.sign_imm_dec_o, 32'(i));
    end
    step();
    check_eq("rel_end_valid", 32'(dq_if.dec_valid_o), 32'd0);

    // simultaneous push+pop keeps count steady while pointers wrap
    dq_if.dec_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (i == 3) dq_if.dec_ready_i = 1'b1;
      present(32'h2108_0000 | 32'(i + 16), 32'h0000_2000 + 32'(4 * i));
      step();
      chk_vc($sformatf("pp%0d", i), 1'b1, (i < 3) ? i : 2,
             32'h0000_2000 + 32'(4 * ((i < 3) ? 0 : i - 2)));
    end
    dq_if.fetch_valid_i = 1'b0;
    step();
    chk_vc("pp_d0", 1'b1, 1, 32'h0000_2010);
    step();
    chk_vc("pp_d1", 1'b1, 0, 32'h0000_2014);
    step();
    check_eq("pp_end_valid", 32'(dq_if.dec_valid_o), 32'd0);

    // flush with 3 queued and a fetch in the same cycle
    dq_if.dec_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      present(32'h2108_0000 | 32'(i + 32), 32'h0000_3000 + 32'(4 * i));
      step();
    end
    check_eq("fl_pre_count", 32'(dq_if.count_o), 32'd3);
    flush_i = 1'b1;
    present(32'h2108_00AA, 32'h0000_3100);
    step();
    check_eq("fl_valid", 32'(dq_if.dec_valid_o), 32'd0);
    check_eq("fl_count", 32'(dq_if.count_o), 32'd0);
    flush_i             = 1'b0;
    dq_if.fetch_valid_i = 1'b0;
    dq_if.dec_ready_i   = 1'b1;
    step();
    check_eq("fl_after_valid", 32'(dq_if.dec_valid_o), 32'd0);
    present(32'h2108_00BB, 32'h0000_3200);
    step();
    chk_vc("fl_new", 1'b1, 0, 32'h0000_3200);
    check_eq("fl_new_imm", dq_if.sign_imm_dec_o, 32'h0000_00BB);
    dq_if.fetch_valid_i = 1'b0;
    step();

    // synchronous reset mid-stream with 2 queued
    dq_if.dec_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      present(32'h2128_0007, 32'h0000_4000 + 32'(4 * i));
      step();
    end
    dq_if.fetch_valid_i = 1'b0;
    rst_n = 1'b0;
    #2;
    chk_vc("rst_async", 1'b1, 2, 32'h0000_4000);
    step();
    chk_vc("rst_mid", 1'b0, 0, 32'h0);
    check_eq("rst_mid_rs", 32'(dq_if.rs_dec_o), 32'd0);
    check_eq("rst_mid_imm", dq_if.sign_imm_dec_o, 32'h0);
    check_eq("rst_mid_is_i", 32'(dq_if.is_i_type_dec_o), 32'd0);
    rst_n             = 1'b1;
    dq_if.dec_ready_i = 1'b1;
    present(32'h2108_0005, 32'h0000_5000);
    step();
    chk_vc("post_rst", 1'b1, 0, 32'h0000_5000);
    dq_if.fetch_valid_i = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
